pe_result_drain: RTL and testbench
==================================

# pe_result_drain

Result-side endpoint of the 8x8 PE cluster. Latches each PE's accumulated result when that PE raises its done flag, waits until every PE has finished, then streams the 64 results out one per accepted beat in row-major order over a valid/ready interface. Sits directly behind `pe_8x8_cluster`, consuming its `results` and `output_dones` buses. Replaces the bench-side "wait for `output_done[63]`, dump the whole bus" unload.

## Interface

- `ROWS`, 8, PE array rows.
- `COLS`, 8, PE array columns.
- `RES_W`, 36, per-PE result width, signed two's complement.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `en`  in  1  global enable; low freezes all state.
- `results`  in  ROWS*COLS*RES_W  cluster result bus; PE (r,c) occupies `[(r*COLS+c)*RES_W +: RES_W]`.
- `pe_done`  in  ROWS*COLS  cluster done flags; bit `r*COLS+c` belongs to PE (r,c).
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  RES_W  result value.
- `out_row`  out  $clog2(ROWS)  row of the current beat.
- `out_col`  out  $clog2(COLS)  column of the current beat.
- `out_last`  out  1  current beat is PE (ROWS-1, COLS-1).
- `busy`  out  1  in COLLECT or DRAIN.
- `all_done`  out  1  every result has been delivered.

## Operation

- **State machine:** IDLE, COLLECT, DRAIN, DONE. All outputs are registered.
- **Capture:** per-PE `captured` flag and RES_W holding register.
  - In IDLE or COLLECT, when `pe_done[i]=1` and `captured[i]=0`, store the result slice and set `captured[i]`.
  - Once set, the flag blocks recapture. Later changes on that slice are ignored.
  - Several PEs may capture in the same cycle.
- **IDLE → COLLECT:** any `pe_done` bit high. The capture of that bit happens on the same edge.
- **COLLECT → DRAIN:** all `captured` flags are 1. Index resets to 0 and `out_valid` is set.
- **DRAIN:**
  - A beat transfers on an edge where `out_valid && out_ready`.
  - After a transfer the index increments and the next beat is presented on the following cycle. Throughput is 1 beat/cycle with `out_ready` held high.
  - `out_row = idx / COLS`, `out_col = idx % COLS`, `out_last = (idx == ROWS*COLS-1)`.
- **DRAIN → DONE:** transfer of the `out_last` beat. `out_valid` drops and `all_done` is set.
- **DONE → IDLE:** `pe_done` is all zero (cluster re-reset). All `captured` flags clear and `all_done` drops.
- **`en` low:** no capture, no state change, no index change. Outputs hold their values. `out_valid` is held, but the handshake is ignored: no transfer occurs while `en=0`.

## Timing

- **Reset values:** state IDLE; `out_valid`, `out_last`, `busy`, `all_done` = 0; `out_data`, `out_row`, `out_col` = 0; all `captured` flags 0.
- **Capture latency:** `pe_done[i]` high at edge N → `captured[i]` set after edge N.
- **Drain start:** final capture at edge N → `out_valid=1` with PE (0,0) after edge N+1.
- **Full drain:** 64 beats take at least 64 cycles.
- **Handshake rules:**
  - While `out_valid && !out_ready`: `out_data`, `out_row`, `out_col` and `out_last` are stable.
  - `out_valid` never drops without a transfer.
- **Reset mid-operation:** `rst_n` low at any edge returns everything to reset values on that edge, including mid-drain. Partially delivered data is discarded.
- **Simultaneous events:**
  - `pe_done` falls while in COLLECT: already captured PEs keep their values; uncaptured PEs wait for their flag.
  - `pe_done` nonzero while in DONE: stay in DONE.

## Configuration

- **`PE_DRAIN_SAT16_EN` defined:** `out_data` is the result clamped to the signed 16-bit range [-32768, 32767], then sign-extended to RES_W.
  - Values above 32767 produce 32767.
  - Values below -32768 produce -32768 (`36'hF_FFFF_8000`).
- **Not defined:** `out_data` is the raw RES_W result.
- Capture storage is full RES_W in both cases.

## Test plan

- **Reset:** hold `rst_n=0` for 3 cycles → all outputs 0, `busy=0`. Raise `pe_done` during reset → no capture.
- **Ordered drain:**
  - Stimulus: PE i result = i+1; all 64 `pe_done` rise together; `out_ready=1`.
  - Response: `out_valid` two edges later; 64 consecutive beats with data 1..64 and (row,col) (0,0)..(7,7); `out_last` on beat 64 only; `all_done=1` the next cycle.
- **Staggered done and post-capture change:**
  - Stimulus: dones arrive in the skewed wavefront, one diagonal per cycle; change PE (0,0)'s result bus to `36'h123` after its capture.
  - Response: drain starts only after PE (7,7) is captured; beat 0 carries the originally latched value, not `36'h123`.
- **Backpressure:** toggle `out_ready` 1,0,0,1 repeating → beat data stable while stalled; no beat lost or duplicated; 64 transfers total.
- **Enable freeze and mid-drain reset:**
  - `en=0` for 5 cycles mid-drain → index and outputs frozen; no transfer even with `out_ready=1`.
  - `rst_n=0` at beat 20 → IDLE, all outputs 0.
- **Saturation (`PE_DRAIN_SAT16_EN`):** PE results 40000, -40000, 1234 → outputs 32767, -32768, 1234. Without the macro → raw values.

Source files
------------

// File: rtl/pe_result_drain.sv
// rtl/pe_result_drain.sv - latch 8x8 PE results on done, then stream them row-major over valid/ready.
// Optional PE_DRAIN_SAT16_EN: out_data is clamped to signed 16-bit and sign-extended.
module pe_result_drain #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int RES_W = 36
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        en_i,
    input  logic [ROWS*COLS*RES_W-1:0]  results_i,
    input  logic [ROWS*COLS-1:0]        pe_done_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [RES_W-1:0]            out_data_o,
    output logic [$clog2(ROWS)-1:0]     out_row_o,
    output logic [$clog2(COLS)-1:0]     out_col_o,
    output logic                        out_last_o,
    output logic                        busy_o,
    output logic                        all_done_o
);
    localparam int N  = ROWS * COLS;
    localparam int IW = $clog2(N);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       captured_q, captured_d;
    logic [RES_W-1:0]   hold_q [N];
    logic [IW-1:0]      idx_q, idx_d, load_idx;
    logic               load, capture_en, fire;
    logic               out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic               busy_q, busy_d, all_done_q, all_done_d;
    logic [RES_W-1:0]   out_data_q, out_data_d;
    logic [RW-1:0]      out_row_q, out_row_d;
    logic [CW-1:0]      out_col_q, out_col_d;

`ifdef PE_DRAIN_SAT16_EN
    localparam logic signed [RES_W-1:0] SAT_MAX = 32767;
    localparam logic signed [RES_W-1:0] SAT_MIN = -32768;
`endif

    function automatic logic [RES_W-1:0] shape(input logic [RES_W-1:0] v);
`ifdef PE_DRAIN_SAT16_EN
        if ($signed(v) > SAT_MAX)      return SAT_MAX;
        else if ($signed(v) < SAT_MIN) return SAT_MIN;
        else                           return v;
`else
        return v;
`endif
    endfunction

    assign capture_en = en_i && (state_q == S_IDLE || state_q == S_COLLECT);
    assign fire       = en_i && out_valid_q && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            captured_q  <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            all_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            captured_q  <= captured_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            all_done_q  <= all_done_d;
        end
    end

    // Holding registers need no reset: they are only read once every flag is set.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < N; i++) begin
            if (capture_en && pe_done_i[i] && !captured_q[i])
                hold_q[i] <= results_i[i*RES_W +: RES_W];
        end
    end

    always_comb begin
        state_d = state_q;
        if (en_i) begin
            case (state_q)
                S_IDLE:    if (|pe_done_i)                 state_d = S_COLLECT;
                S_COLLECT: if (&captured_q)                state_d = S_DRAIN;
                S_DRAIN:   if (fire && out_last_q)         state_d = S_DONE;
                S_DONE:    if (pe_done_i == '0)            state_d = S_IDLE;
                default:                                   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        captured_d  = captured_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        load        = 1'b0;
        load_idx    = idx_q;
        if (en_i && state_q == S_DONE && state_d == S_IDLE)
            captured_d = '0;
        else if (capture_en)
            captured_d = captured_q | pe_done_i;

        if (state_q == S_COLLECT && state_d == S_DRAIN) begin
            idx_d       = '0;
            out_valid_d = 1'b1;
            load        = 1'b1;
            load_idx    = '0;
        end else if (state_q == S_DRAIN && fire) begin
            if (out_last_q) begin
                out_valid_d = 1'b0;
            end else begin
                idx_d    = idx_q + IW'(1);
                load     = 1'b1;
                load_idx = idx_q + IW'(1);
            end
        end

        out_data_d = load ? shape(hold_q[load_idx])          : out_data_q;
        out_row_d  = load ? RW'(load_idx / IW'(COLS))        : out_row_q;
        out_col_d  = load ? CW'(load_idx % IW'(COLS))        : out_col_q;
        out_last_d = load ? (load_idx == IW'(N-1))           : out_last_q;
        busy_d     = (state_d == S_COLLECT) || (state_d == S_DRAIN);
        all_done_d = (state_d == S_DONE);
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_row_o   = out_row_q;
    assign out_col_o   = out_col_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = busy_q;
    assign all_done_o  = all_done_q;
endmodule

// File: tb/tb_pe_result_drain.sv
// tb/tb_pe_result_drain.sv - randomized scoreboard bench for pe_result_drain.
module tb_pe_result_drain;
    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int RES_W = 36;
    localparam int N     = ROWS * COLS;

    logic                   clk = 1'b0;
    logic                   rst_n, en, out_ready, out_valid, out_last, busy, all_done;
    logic [N*RES_W-1:0]     results;
    logic [N-1:0]           pe_done;
    logic [RES_W-1:0]       out_data;
    logic [2:0]             out_row, out_col;

    always #5 clk = ~clk;

    pe_result_drain #(.ROWS(ROWS), .COLS(COLS), .RES_W(RES_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .results_i(results), .pe_done_i(pe_done),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_row_o(out_row), .out_col_o(out_col), .out_last_o(out_last),
        .busy_o(busy), .all_done_o(all_done)
    );

    typedef struct { logic [RES_W-1:0] data; int idx; } beat_t;
    beat_t            exp_q[$];
    logic [RES_W-1:0] vals[N];
    int               n_checks = 0;
    int               n_fail   = 0;
    int               beats    = 0;
    int               rdy_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [RES_W-1:0] model_out(input logic [RES_W-1:0] v);
`ifdef PE_DRAIN_SAT16_EN
        longint s = longint'($signed(v));
        if (s > 32767)       s = 32767;
        else if (s < -32768) s = -32768;
        return RES_W'(s);
`else
        return v;
`endif
    endfunction

    function automatic logic [RES_W-1:0] rand_res();
        return {$urandom_range(0, 15), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drain order is row-major over the values latched at each PE's first done.
    task automatic push_expected();
        for (int i = 0; i < N; i++) exp_q.push_back('{model_out(vals[i]), i});
    endtask

    task automatic load_results();
        for (int i = 0; i < N; i++) results[i*RES_W +: RES_W] = vals[i];
    endtask

    task automatic apply_together();
        load_results();
        push_expected();
        pe_done = '1;
        tick();
    endtask

    task automatic wait_done(input string tag, input int bound);
        int cnt = 0;
        while (!all_done && cnt < bound) begin tick(); cnt++; end
        check({tag, "_done_timeout"}, 64'(all_done), 64'd1);
    endtask

    task automatic finish_run(input string tag);
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_beat_count"}, 64'(beats), 64'(N));
        pe_done = '0;
        tick();
        check({tag, "_all_done_drop"}, 64'(all_done), 64'd0);
        check({tag, "_busy_idle"}, 64'(busy), 64'd0);
        beats = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_data"}, 64'(out_data), 64'd0);
        check({tag, "_row"}, 64'(out_row), 64'd0);
        check({tag, "_col"}, 64'(out_col), 64'd0);
        check({tag, "_last"}, 64'(out_last), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_all_done"}, 64'(all_done), 64'd0);
    endtask

    initial begin
        int k = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       out_ready = (k % 4 == 0) || (k % 4 == 3);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
            k++;
        end
    end

    // Monitor: pops one expected beat per accepted transfer and checks stall stability.
    initial begin
        logic             hold_prev = 1'b0;
        logic             expect_done = 1'b0;
        logic [RES_W-1:0] snap_data;
        logic [2:0]       snap_row, snap_col;
        logic             snap_last;
        beat_t            b;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_prev   = 1'b0;
                expect_done = 1'b0;
            end else begin
                if (expect_done) begin
                    check("all_done_after_last", 64'(all_done), 64'd1);
                    check("valid_drop_after_last", 64'(out_valid), 64'd0);
                    expect_done = 1'b0;
                end
                if (hold_prev) begin
                    check("stall_valid_held", 64'(out_valid), 64'd1);
                    check("stall_data_stable", 64'(out_data), 64'(snap_data));
                    check("stall_rowcol_stable", 64'({out_row, out_col, out_last}),
                          64'({snap_row, snap_col, snap_last}));
                end
                if (out_valid && out_ready && en) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 64'd1, 64'd0);
                    end else begin
                        b = exp_q.pop_front();
                        check("beat_data", 64'(out_data), 64'(b.data));
                        check("beat_row", 64'(out_row), 64'(b.idx / COLS));
                        check("beat_col", 64'(out_col), 64'(b.idx % COLS));
                        check("beat_last", 64'(out_last), 64'(b.idx == N - 1));
                        if (b.idx == N - 1) expect_done = 1'b1;
                    end
                    beats++;
                end
                hold_prev = out_valid && !(out_ready && en);
                snap_data = out_data;
                snap_row  = out_row;
                snap_col  = out_col;
                snap_last = out_last;
            end
        end
    end

    initial begin
        int cnt, b0;
        rst_n = 1'b0; en = 1'b1; pe_done = '1;
        for (int i = 0; i < N; i++) vals[i] = rand_res();
        load_results();
        repeat (3) tick();
        check_reset_outputs("reset");
        pe_done = '0;
        rst_n   = 1'b1;
        tick(); tick();
        check("post_reset_busy", 64'(busy), 64'd0);

        // Ordered drain; a capture during reset would block these values.
        for (int i = 0; i < N; i++) vals[i] = RES_W'(i + 1);
        apply_together();
        check("ordered_valid_edge1", 64'(out_valid), 64'd0);
        check("ordered_busy_edge1", 64'(busy), 64'd1);
        tick();
        check("ordered_valid_edge2", 64'(out_valid), 64'd1);
        cnt = 0;
        while (!all_done && cnt < 200) begin tick(); cnt++; end
        check("ordered_drain_cycles", 64'(cnt), 64'(N));
        repeat (3) begin
            tick();
            check("done_holds_with_pe_done", 64'(all_done), 64'd1);
        end
        finish_run("ordered");

        // Skewed wavefront with pulsed dones; PE (0,0) bus changes after capture.
        for (int i = 0; i < N; i++) vals[i] = rand_res();
        load_results();
        push_expected();
        for (int d = 0; d <= ROWS + COLS - 2; d++) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    pe_done[r*COLS+c] = (r + c == d);
            tick();
            if (d == 0) results[0 +: RES_W] = 36'h123;
            check("stagger_no_early_valid", 64'(out_valid), 64'd0);
        end
        tick();
        check("stagger_valid_after_last_capture", 64'(out_valid), 64'd1);
        wait_done("stagger", 200);
        finish_run("stagger");

        // Backpressure with ready pattern 1,0,0,1.
        rdy_mode = 1;
        for (int i = 0; i < N; i++) vals[i] = rand_res();
        apply_together();
        wait_done("backpressure", 600);
        finish_run("backpressure");

        // Enable freeze mid-drain, then reset at beat 20.
        rdy_mode = 0;
        for (int i = 0; i < N; i++) vals[i] = rand_res();
        apply_together();
        cnt = 0;
        while (beats < 8 && cnt < 200) begin tick(); cnt++; end
        check("freeze_reach_beat8", 64'(beats >= 8), 64'd1);
        en = 1'b0;
        b0 = beats;
        repeat (5) tick();
        check("freeze_no_transfer", 64'(beats), 64'(b0));
        check("freeze_valid_held", 64'(out_valid), 64'd1);
        check("freeze_busy_held", 64'(busy), 64'd1);
        en = 1'b1;
        cnt = 0;
        while (beats < 20 && cnt < 200) begin tick(); cnt++; end
        check("reach_beat20", 64'(beats), 64'd20);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("mid_drain_reset");
        exp_q.delete();
        rst_n   = 1'b1;
        pe_done = '0;
        beats   = 0;
        tick();
        check("after_reset_idle", 64'(busy), 64'd0);

        // Saturation boundaries with random ready.
        rdy_mode = 2;
        for (int i = 0; i < N; i++) begin
            case (i % 4)
                0:       vals[i] = RES_W'(40000);
                1:       vals[i] = RES_W'(-40000);
                2:       vals[i] = RES_W'(1234);
                default: vals[i] = rand_res();
            endcase
        end
        apply_together();
        wait_done("saturation", 800);
        finish_run("saturation");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
